gf180mcu_rst_release_seq: RTL

// - Reset-release sequencer for banks of async-clear flops (dffrnq-style, RN active-low) in one clock domain.
// - Asserts all domain resets asynchronously on chip reset.
// - Releases domain resets synchronously, one domain at a time, with a programmable gap between releases.
// - Also runs a software-requested reset cycle over a req/ack handshake; sits between the chip reset pin and the datapath flop banks.

---
 rtl/gf180mcu_rst_release_seq_if.sv | 21 ++
 rtl/gf180mcu_rst_release_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gf180mcu_rst_release_seq_if.sv
// Software-reset handshake and per-domain reset outputs of the reset-release sequencer.
// GF180_RSTSEQ_STATUS_EN adds the rel_cnt status output.
interface gf180mcu_rst_release_seq_if #(
   parameter int NUM_DOM = 4
);
   localparam int RCW = (NUM_DOM + 1 > 1) ? $clog2(NUM_DOM + 1) : 1;

   logic               sw_rst_req;
   logic               sw_rst_ack;
   logic [NUM_DOM-1:0] dom_rn;
   logic               ready;
`ifdef GF180_RSTSEQ_STATUS_EN
   logic [RCW-1:0]     rel_cnt;

   modport master (output sw_rst_req, input sw_rst_ack, input dom_rn, input ready, input rel_cnt);
   modport slave  (input sw_rst_req, output sw_rst_ack, output dom_rn, output ready, output rel_cnt);
`else
   modport master (output sw_rst_req, input sw_rst_ack, input dom_rn, input ready);
   modport slave  (input sw_rst_req, output sw_rst_ack, output dom_rn, output ready);
`endif
endinterface

// File: rtl/gf180mcu_rst_release_seq.sv
// Reset-release sequencer: async assert, staggered synchronous release of NUM_DOM domain resets.
// GF180_RSTSEQ_STATUS_EN adds a registered count of released domains (bus.rel_cnt).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HOLD    | chip reset just released, waiting for synchronized rn
// ST_RELEASE | releasing domains in ascending order, one per STAGE_CYC
// ST_RUN     | all domains released, watching for software requests
// ST_ASSERT  | all domains held in reset for STAGE_CYC clocks (SW cycle)
module gf180mcu_rst_release_seq #(
   parameter int NUM_DOM     = 4,
   parameter int STAGE_CYC   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rn,
   gf180mcu_rst_release_seq_if.slave   bus
);

   localparam int CNTW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
   localparam int IDXW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam logic [CNTW-1:0] CNT_TC   = CNTW'(STAGE_CYC - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_DOM - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_ASSERT  = 2'd3
   } state_t;

   state_t             state_q, state_nxt;
   logic [CNTW-1:0]    cnt_q, cnt_nxt;
   logic [IDXW-1:0]    idx_q, idx_nxt;
   logic [NUM_DOM-1:0] dom_q, dom_nxt;
   logic               ready_q, ready_nxt;
   logic               ack_q, ack_nxt;
   logic               sw_q, sw_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               rn_sync;

   assign rn_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         sw_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         idx_q   <= idx_nxt;
         dom_q   <= dom_nxt;
         ready_q <= ready_nxt;
         ack_q   <= ack_nxt;
         sw_q    <= sw_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      idx_nxt   = idx_q;
      dom_nxt   = dom_q;
      ready_nxt = ready_q;
      ack_nxt   = 1'b0;
      sw_nxt    = sw_q;
      case (state_q)
         ST_HOLD: begin
            if (rn_sync) begin
               state_nxt = ST_RELEASE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == CNT_TC) begin
               cnt_nxt        = '0;
               dom_nxt[idx_q] = 1'b1;
               idx_nxt        = idx_q + IDXW'(1);
               if (idx_q == IDX_LAST) begin
                  // last domain: idx parks at 0 rather than wrapping past NUM_DOM-1
                  idx_nxt   = '0;
                  state_nxt = ST_RUN;
                  ready_nxt = 1'b1;
                  ack_nxt   = sw_q;
                  sw_nxt    = 1'b0;
               end
            end else begin
               cnt_nxt = cnt_q + CNTW'(1);
            end
         end
         ST_RUN: begin
            if (bus.sw_rst_req) begin
               dom_nxt   = '0;
               ready_nxt = 1'b0;
               sw_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (cnt_q == CNT_TC) begin
               state_nxt = ST_RELEASE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CNTW'(1);
            end
         end
         default: state_nxt = ST_HOLD;
      endcase
   end

   assign bus.dom_rn     = dom_q;
   assign bus.ready      = ready_q;
   assign bus.sw_rst_ack = ack_q;

`ifdef GF180_RSTSEQ_STATUS_EN
   localparam int RCW = (NUM_DOM + 1 > 1) ? $clog2(NUM_DOM + 1) : 1;
   logic [RCW-1:0] rel_q;

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         rel_q <= '0;
      end else if (state_q == ST_RUN && bus.sw_rst_req) begin
         rel_q <= '0;
      end else if (state_q == ST_RELEASE && cnt_q == CNT_TC) begin
         rel_q <= rel_q + RCW'(1);
      end
   end

   assign bus.rel_cnt = rel_q;
`endif

endmodule
